alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 120 ++++++++++++
 tb/tb_alu.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu -- self-sequencing registered ALU
//
// Purpose:
//   This ALU has no opcode input. An internal 3-bit selector, ALU_Sel, steps
//   through the eight operations in order and wraps from 111 back to 000:
//     000 ADD
//     001 SUB
//     010 AND
//     011 OR
//     100 XOR
//     101 XNOR
//     110 NAND
//     111 NOR
//   On every rising edge out of reset, the block does three things on the
//   same edge:
//     - registers f(ALU_Sel, A, B) into ALU_Out,
//     - registers the carry/borrow flag into CarryOut,
//     - advances ALU_Sel by one.
//   Latency is therefore exactly one cycle. ALU_Sel is kept as a named
//   register so that benches can read it hierarchically; it acts as the
//   block's visible state.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low; clears ALU_Sel, ALU_Out, CarryOut
//   A, B      in   WIDTH-bit unsigned operands
//   ALU_Out   out  WIDTH-bit registered result
//   CarryOut  out  registered flag:
//                    ADD  carry out of bit WIDTH-1
//                    SUB  borrow (A < B)
//                    logic ops  0
// ----------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut
);

    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_SUB  = 3'b001;
    localparam logic [2:0] SEL_AND  = 3'b010;
    localparam logic [2:0] SEL_OR   = 3'b011;
    localparam logic [2:0] SEL_XOR  = 3'b100;
    localparam logic [2:0] SEL_XNOR = 3'b101;
    localparam logic [2:0] SEL_NAND = 3'b110;
    localparam logic [2:0] SEL_NOR  = 3'b111;

    // Operation selector register; the name is kept for hierarchical access.
    logic [2:0]       ALU_Sel;
    logic [2:0]       alu_sel_d;

    logic [WIDTH-1:0] alu_out_q;
    logic [WIDTH-1:0] alu_out_d;
    logic             carry_q;
    logic             carry_d;

    // Both arithmetic results are one bit wider than the operands. For the
    // sum, the top bit is the carry. For the difference of zero-extended
    // operands, the top bit is set exactly when A < B, so it is the borrow.
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;

    always_comb begin
        sum_w     = {1'b0, A} + {1'b0, B};
        diff_w    = {1'b0, A} - {1'b0, B};

        alu_out_d = '0;
        carry_d   = 1'b0;

        // Wraps 111 -> 000 naturally in 3 bits.
        alu_sel_d = ALU_Sel + 3'd1;

        case (ALU_Sel)
            SEL_ADD: begin
                alu_out_d = sum_w[WIDTH-1:0];
                carry_d   = sum_w[WIDTH];
            end
            SEL_SUB: begin
                alu_out_d = diff_w[WIDTH-1:0];
                carry_d   = diff_w[WIDTH];
            end
            SEL_AND:  alu_out_d = A & B;
            SEL_OR:   alu_out_d = A | B;
            SEL_XOR:  alu_out_d = A ^ B;
            SEL_XNOR: alu_out_d = ~(A ^ B);
            SEL_NAND: alu_out_d = ~(A & B);
            SEL_NOR:  alu_out_d = ~(A | B);
            default: begin
                alu_out_d = '0;
                carry_d   = 1'b0;
            end
        endcase
    end

    // Reset wins at any selector value; no operation is performed on a
    // reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ALU_Sel   <= SEL_ADD;
            alu_out_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            ALU_Sel   <= alu_sel_d;
            alu_out_q <= alu_out_d;
            carry_q   <= carry_d;
        end
    end

    // Outputs come straight from flops, so there is no combinational path
    // from A or B to the outputs.
    assign ALU_Out  = alu_out_q;
    assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (WIDTH = 8)
//
// The reference model computes each operation from its arithmetic and
// bitwise definition using plain integers. It tracks the selector as a
// simple modulo-8 step count that restarts at 0 on reset.
//
// Timing: inputs change and outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_alu;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] alu_out;
    logic         carry_out;

    int checks;
    int failures;

    // Modulo-8 step count the model expects ALU_Sel to hold.
    int model_sel;

    // Expected {carry, result} pairs, filled and drained by the scenarios.
    logic [W:0] exp_q[$];

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (a),
        .B        (b),
        .ALU_Out  (alu_out),
        .CarryOut (carry_out)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: returns {carry, result} for step number sel.
    // ------------------------------------------------------------------
    function automatic logic [W:0] ref_op(input int sel, input int av, input int bv);
        int m;
        int r;
        int c;
        m = 2 ** W;
        c = 0;
        case (sel % 8)
            0: begin
                r = (av + bv) % m;
                c = (av + bv >= m) ? 1 : 0;
            end
            1: begin
                r = (av - bv + m) % m;
                c = (av < bv) ? 1 : 0;
            end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = (m - 1) - (av ^ bv);
            6: r = (m - 1) - (av & bv);
            default: r = (m - 1) - (av | bv);
        endcase
        ref_op = {c[0], r[W-1:0]};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled edge with the current A/B. The model steps alongside the
    // DUT and the expected pair is pushed onto the queue.
    task automatic enabled_edge();
        exp_q.push_back(ref_op(model_sel, int'(a), int'(b)));
        model_sel = (model_sel + 1) % 8;
        tick();
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
        model_sel = 0;
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------

    // Reset clears all registers, and holding reset keeps them cleared even
    // while the operands keep changing.
    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            tick();
            checks++;
            if (alu_out !== 8'h00 || carry_out !== 1'b0 || dut.ALU_Sel !== 3'b000) begin
                failures++;
                $display("FAIL reset_hold[%0d]: out=%h carry=%b sel=%b, required out=00 carry=0 sel=000",
                         i, alu_out, carry_out, dut.ALU_Sel);
            end
        end
        reset = 1'b1;
        model_sel = 0;
        exp_q.delete();
    endtask

    // Directed 8-step pass with A=0x0F, B=0x03, checked against both the
    // constant table and the model.
    task automatic test_directed_sequence();
        logic [W:0] table_v[8];
        logic [W:0] e;
        table_v = '{9'h012, 9'h00C, 9'h003, 9'h00F, 9'h00C, 9'h0F3, 9'h0FC, 9'h0F0};
        apply_reset(1);
        a = 8'h0F;
        b = 8'h03;
        for (int i = 0; i < 8; i++) begin
            enabled_edge();
            e = exp_q.pop_front();
            checks++;
            if ({carry_out, alu_out} !== table_v[i] || e !== table_v[i]) begin
                failures++;
                $display("FAIL directed_seq[%0d]: got %b/%h model %h, required %h",
                         i, carry_out, alu_out, e, table_v[i]);
            end
        end
        checks++;
        if (dut.ALU_Sel !== 3'b000) begin
            failures++;
            $display("FAIL directed_sel_wrap: sel=%b, required 000", dut.ALU_Sel);
        end
    endtask

    // ADD overflow on the first enabled edge after reset.
    task automatic test_add_overflow();
        apply_reset(1);
        a = 8'hFF;
        b = 8'h01;
        enabled_edge();
        void'(exp_q.pop_front());
        checks++;
        if (alu_out !== 8'h00 || carry_out !== 1'b1) begin
            failures++;
            $display("FAIL add_overflow: out=%h carry=%b, required out=00 carry=1",
                     alu_out, carry_out);
        end
        checks++;
        if (dut.ALU_Sel !== 3'b001) begin
            failures++;
            $display("FAIL add_advance: sel=%b, required 001", dut.ALU_Sel);
        end
    endtask

    // SUB slot: borrow when A < B, and no borrow when A == B.
    task automatic test_sub_borrow();
        apply_reset(1);
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        enabled_edge();
        void'(exp_q.pop_front());
        a = 8'h03;
        b = 8'h0F;
        enabled_edge();
        void'(exp_q.pop_front());
        checks++;
        if (alu_out !== 8'hF4 || carry_out !== 1'b1) begin
            failures++;
            $display("FAIL sub_borrow: out=%h carry=%b, required out=f4 carry=1",
                     alu_out, carry_out);
        end

        apply_reset(1);
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        enabled_edge();
        void'(exp_q.pop_front());
        a = 8'h55;
        b = 8'h55;
        enabled_edge();
        void'(exp_q.pop_front());
        checks++;
        if (alu_out !== 8'h00 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL sub_equal: out=%h carry=%b, required out=00 carry=0",
                     alu_out, carry_out);
        end
    endtask

    // Reset in the middle of the sequence restarts it at ADD.
    task automatic test_reset_mid();
        apply_reset(1);
        a = 8'h21;
        b = 8'h42;
        repeat (3) enabled_edge();
        exp_q.delete();
        checks++;
        if (dut.ALU_Sel !== 3'b011) begin
            failures++;
            $display("FAIL mid_pre_sel: sel=%b, required 011", dut.ALU_Sel);
        end
        apply_reset(1);
        checks++;
        if (dut.ALU_Sel !== 3'b000 || alu_out !== 8'h00 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: sel=%b out=%h carry=%b, required 000/00/0",
                     dut.ALU_Sel, alu_out, carry_out);
        end
        a = 8'hC8;
        b = 8'h64;
        enabled_edge();
        void'(exp_q.pop_front());
        // 0xC8 + 0x64 = 0x12C: result 0x2C with carry set.
        checks++;
        if (alu_out !== 8'h2C || carry_out !== 1'b1) begin
            failures++;
            $display("FAIL mid_first_add: out=%h carry=%b, required out=2c carry=1",
                     alu_out, carry_out);
        end
    endtask

    // 16 consecutive edges: the 8-entry sequence must appear exactly twice.
    task automatic test_wrap();
        logic [W:0] table_v[8];
        table_v = '{9'h012, 9'h00C, 9'h003, 9'h00F, 9'h00C, 9'h0F3, 9'h0FC, 9'h0F0};
        apply_reset(1);
        a = 8'h0F;
        b = 8'h03;
        for (int i = 0; i < 16; i++) begin
            enabled_edge();
            void'(exp_q.pop_front());
            checks++;
            if ({carry_out, alu_out} !== table_v[i % 8]) begin
                failures++;
                $display("FAIL wrap[%0d]: got %b/%h, required %h",
                         i, carry_out, alu_out, table_v[i % 8]);
            end
        end
    endtask

    // Operand changes between edges must not reach the outputs before the
    // next rising edge.
    task automatic test_mid_cycle();
        logic [W:0] held;
        logic [W:0] e;
        apply_reset(1);
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            enabled_edge();
            held = exp_q.pop_front();
            #2;
            a = ~a;
            b = b + 8'd37;
            #2;
            checks++;
            if ({carry_out, alu_out} !== held) begin
                failures++;
                $display("FAIL mid_cycle_hold[%0d]: got %b/%h, required %h",
                         i, carry_out, alu_out, held);
            end
            enabled_edge();
            e = exp_q.pop_front();
            checks++;
            if ({carry_out, alu_out} !== e) begin
                failures++;
                $display("FAIL mid_cycle_next[%0d]: got %b/%h, required %h",
                         i, carry_out, alu_out, e);
            end
        end
    endtask

    // Random operands with occasional resets, checked against the model.
    task automatic test_random();
        logic [W:0] e;
        apply_reset(1);
        for (int i = 0; i < 300; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                apply_reset(1);
                checks++;
                if (alu_out !== 8'h00 || carry_out !== 1'b0 || dut.ALU_Sel !== 3'b000) begin
                    failures++;
                    $display("FAIL rand_reset[%0d]: out=%h carry=%b sel=%b, required 00/0/000",
                             i, alu_out, carry_out, dut.ALU_Sel);
                end
            end else begin
                enabled_edge();
                e = exp_q.pop_front();
                checks++;
                if ({carry_out, alu_out} !== e || dut.ALU_Sel !== 3'(model_sel)) begin
                    failures++;
                    $display("FAIL rand[%0d]: got %b/%h sel=%b, required %h sel=%0d",
                             i, carry_out, alu_out, dut.ALU_Sel, e, model_sel);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        checks    = 0;
        failures  = 0;
        model_sel = 0;
        reset     = 1'b0;
        a         = '0;
        b         = '0;

        test_reset();
        test_directed_sequence();
        test_add_overflow();
        test_sub_borrow();
        test_reset_mid();
        test_wrap();
        test_mid_cycle();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
